// File: rtl/addr_mu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_mu_pkg : shared types and default widths for the dnoc           |
// |               nested-loop address generator                          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package addr_mu_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int C_NUM_LOOP = 4;
  localparam int C_ADDR_W   = 13;
  localparam int C_CNT_W    = 13;

endpackage
`default_nettype wire

// File: rtl/addr_mu_loop.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_mu_loop : one nesting level (iteration counter + address offset)|
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module addr_mu_loop
  import addr_mu_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int CNT_W  = C_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [CNT_W-1:0]  lenth,
  input  logic [ADDR_W-1:0] gap,
  output logic [ADDR_W-1:0] offset_nxt,
  output logic              at_target
);

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_offset;
  logic [CNT_W-1:0]  w_cnt_nxt;

  assign at_target = (r_cnt == lenth);

  // offset_nxt is exported so the top can form the next address in the same cycle
  always_comb begin
    w_cnt_nxt  = r_cnt;
    offset_nxt = r_offset;
    if (clr) begin
      w_cnt_nxt  = '0;
      offset_nxt = '0;
    end else if (step) begin
      if (at_target) begin
        w_cnt_nxt  = '0;
        offset_nxt = '0;
      end else begin
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        offset_nxt = r_offset + gap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_offset <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_offset <= offset_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/addr_mu_nd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addr_mu_nd : N-level nested-loop address generator with valid/ready  |
// |              output, last/done flags and one-shot or wrap mode       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module addr_mu_nd
  import addr_mu_pkg::*;
#(
  parameter int NUM_LOOP = C_NUM_LOOP,
  parameter int ADDR_W   = C_ADDR_W,
  parameter int CNT_W    = C_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic [NUM_LOOP*ADDR_W-1:0]   cfg_gap,
  input  logic [NUM_LOOP*CNT_W-1:0]    cfg_lenth,
  input  logic                         cfg_wrap,
  input  logic                         start,
  output logic                         addr_vld,
  input  logic                         addr_rdy,
  output logic [ADDR_W-1:0]            addr_out,
  output logic                         addr_last,
  output logic                         done,
  output logic                         busy
);

  state_e                       r_state;
  state_e                       w_state_nxt;
  logic [ADDR_W-1:0]            r_base;
  logic [NUM_LOOP*ADDR_W-1:0]   r_gap;
  logic [NUM_LOOP*CNT_W-1:0]    r_lenth;
  logic                         r_wrap;
  logic [ADDR_W-1:0]            r_addr;
  logic                         r_done;

  logic [NUM_LOOP-1:0]          w_step;
  logic [NUM_LOOP-1:0]          w_at_target;
  logic [ADDR_W-1:0]            w_off_nxt [NUM_LOOP];
  logic [ADDR_W-1:0]            w_addr_nxt;
  logic                         w_vld;
  logic                         w_adv;
  logic                         w_all_target;
  logic                         w_final;

  // start outranks a same-cycle handshake
  assign w_adv        = w_vld & addr_rdy & ~start;
  assign w_all_target = &w_at_target;
  assign w_final      = w_adv & w_all_target & ~r_wrap;

  // odometer carry: a level steps only when every inner level is at target
  assign w_step[NUM_LOOP-1] = w_adv;
  for (genvar i = 0; i < NUM_LOOP - 1; i++) begin : g_step
    assign w_step[i] = w_step[i+1] & w_at_target[i+1];
  end

  for (genvar i = 0; i < NUM_LOOP; i++) begin : g_loop
    addr_mu_loop #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_loop (
      .clk        (clk),
      .rst        (rst),
      .clr        (start),
      .step       (w_step[i]),
      .lenth      (r_lenth[i*CNT_W +: CNT_W]),
      .gap        (r_gap[i*ADDR_W +: ADDR_W]),
      .offset_nxt (w_off_nxt[i]),
      .at_target  (w_at_target[i])
    );
  end

  always_comb begin
    w_addr_nxt = r_base;
    for (int i = 0; i < NUM_LOOP; i++) begin
      w_addr_nxt = w_addr_nxt + w_off_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = RUN;
    end else if (w_final) begin
      w_state_nxt = IDLE;
    end
  end

  always_comb begin
    w_vld = (r_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base  <= '0;
      r_gap   <= '0;
      r_lenth <= '0;
      r_wrap  <= 1'b0;
    end else if (start) begin
      r_base  <= cfg_base_addr;
      r_gap   <= cfg_gap;
      r_lenth <= cfg_lenth;
      r_wrap  <= cfg_wrap;
    end
  end

  // a one-shot run keeps showing its final address after completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_final;
      if (start) begin
        r_addr <= cfg_base_addr;
      end else if (w_adv && !w_final) begin
        r_addr <= w_addr_nxt;
      end
    end
  end

  assign addr_vld  = w_vld;
  assign busy      = w_vld;
  assign addr_out  = r_addr;
  assign addr_last = w_vld & w_all_target;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_addr_mu_nd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_addr_mu_nd : directed vectors and randomized runs against a       |
// |                 mixed-radix reference model                          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_addr_mu_nd;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, wrap_a, rdy_a;
  logic [12:0] base_a;
  logic [51:0] gap_a, len_a;
  logic        vld_a, last_a, done_a, busy_a;
  logic [12:0] out_a;

  logic        start_b, wrap_b, rdy_b;
  logic [15:0] base_b;
  logic [95:0] gap_b;
  logic [77:0] len_b;
  logic        vld_b, last_b, done_b, busy_b;
  logic [15:0] out_b;

  addr_mu_nd #(.NUM_LOOP(4), .ADDR_W(13), .CNT_W(13)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_base_addr(base_a), .cfg_gap(gap_a), .cfg_lenth(len_a),
    .cfg_wrap(wrap_a), .start(start_a), .addr_vld(vld_a), .addr_rdy(rdy_a),
    .addr_out(out_a), .addr_last(last_a), .done(done_a), .busy(busy_a)
  );

  addr_mu_nd #(.NUM_LOOP(6), .ADDR_W(16), .CNT_W(13)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_base_addr(base_b), .cfg_gap(gap_b), .cfg_lenth(len_b),
    .cfg_wrap(wrap_b), .start(start_b), .addr_vld(vld_b), .addr_rdy(rdy_b),
    .addr_out(out_b), .addr_last(last_b), .done(done_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [12:0]      base;
    logic [0:3][12:0] g;
    logic [0:3][12:0] l;
    logic             wrap;
    logic [3:0]       n;
    logic [0:7][12:0] exp;
    logic [7:0]       last_mask;
    logic             done;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // k-th address of the sequence: k written in mixed radix (lenth+1 per level)
  function automatic int ref_addr(int nl, int aw, int base, int g[6], int l[6], int k);
    int acc = base;
    int r   = k;
    for (int i = nl - 1; i >= 0; i--) begin
      acc += (r % (l[i] + 1)) * g[i];
      r    = r / (l[i] + 1);
    end
    return acc & ((1 << aw) - 1);
  endfunction

  task automatic sample(input int which, output int v, output int a, output int la,
                        output int d, output int b);
    if (which == 0) begin
      v = int'(vld_a); a = int'(out_a); la = int'(last_a); d = int'(done_a); b = int'(busy_a);
    end else begin
      v = int'(vld_b); a = int'(out_b); la = int'(last_b); d = int'(done_b); b = int'(busy_b);
    end
  endtask

  task automatic set_rdy(input int which, input bit r);
    if (which == 0) rdy_a = r;
    else            rdy_b = r;
  endtask

  task automatic apply_vec(input vec_t v);
    base_a = v.base;
    wrap_a = v.wrap;
    for (int i = 0; i < 4; i++) begin
      gap_a[i*13 +: 13] = v.g[i];
      len_a[i*13 +: 13] = v.l[i];
    end
    rdy_a   = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 0; k < int'(v.n); k++) begin
      chk("vec_vld", int'(vld_a), 1);
      chk("vec_addr", int'(out_a), int'(v.exp[k]));
      chk("vec_last", int'(last_a), int'(v.last_mask[k]));
      rdy_a = 1'b1;
      @(posedge clk); #1;
    end
    rdy_a = 1'b0;
    chk("vec_done", int'(done_a), int'(v.done));
    chk("vec_busy", int'(busy_a), int'(!v.done));
    chk("vec_hold", int'(out_a), v.done ? int'(v.exp[int'(v.n) - 1]) : int'(v.exp[0]));
    @(posedge clk); #1;
    chk("vec_done_pulse", int'(done_a), 0);
  endtask

  // mode 0: rdy always 1, mode 1: rdy 1010.., mode 2: random rdy
  task automatic run_seq(input int which, input int base, input int g[6], input int l[6],
                         input bit wrap, input int mode);
    int nl    = (which == 0) ? 4 : 6;
    int aw    = (which == 0) ? 13 : 16;
    int total = 1;
    int idx   = 0;
    int cyc   = 0;
    int n_hs;
    bit r;
    int v, a, la, d, b;
    for (int i = 0; i < nl; i++) total *= l[i] + 1;
    n_hs = wrap ? total + 3 : total;
    if (which == 0) begin
      base_a = 13'(base); wrap_a = wrap;
      for (int i = 0; i < 4; i++) begin
        gap_a[i*13 +: 13] = 13'(g[i]);
        len_a[i*13 +: 13] = 13'(l[i]);
      end
      start_a = 1'b1;
    end else begin
      base_b = 16'(base); wrap_b = wrap;
      for (int i = 0; i < 6; i++) begin
        gap_b[i*16 +: 16] = 16'(g[i]);
        len_b[i*13 +: 13] = 13'(l[i]);
      end
      start_b = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    while (idx < n_hs && cyc < 5000) begin
      sample(which, v, a, la, d, b);
      chk("run_vld", v, 1);
      chk("run_busy", b, 1);
      chk("run_addr", a, ref_addr(nl, aw, base, g, l, idx % total));
      chk("run_last", la, int'((idx % total) == total - 1));
      chk("run_done_low", d, 0);
      if (mode == 0)      r = 1'b1;
      else if (mode == 1) r = (cyc % 2 == 0);
      else                r = 1'($urandom_range(0, 1));
      set_rdy(which, r);
      @(posedge clk); #1;
      cyc++;
      if (r) idx++;
    end
    set_rdy(which, 1'b0);
    chk("run_budget", int'(idx >= n_hs), 1);
    sample(which, v, a, la, d, b);
    if (!wrap) begin
      chk("run_end_done", d, 1);
      chk("run_end_vld", v, 0);
      chk("run_end_busy", b, 0);
      chk("run_end_hold", a, ref_addr(nl, aw, base, g, l, total - 1));
    end else begin
      chk("run_wrap_nodone", d, 0);
      chk("run_wrap_vld", v, 1);
    end
  endtask

  initial begin
    int g[6];
    int l[6];
    int nl, aw, mask, which;
    bit wrap;

    rst = 1'b1;
    start_a = 1'b0; wrap_a = 1'b0; rdy_a = 1'b0; base_a = '0; gap_a = '0; len_a = '0;
    start_b = 1'b0; wrap_b = 1'b0; rdy_b = 1'b0; base_b = '0; gap_b = '0; len_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", int'(vld_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_addr", int'(out_a), 0);
    chk("rst_last", int'(last_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_b_vld", int'(vld_b), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start", int'(vld_a), 0);

    vecs[0] = '{13'h100, '{13'h0, 13'h0, 13'h10, 13'h1}, '{13'd0, 13'd0, 13'd1, 13'd2}, 1'b0, 4'd6,
                '{13'h100, 13'h101, 13'h102, 13'h110, 13'h111, 13'h112, 13'h0, 13'h0},
                8'b0010_0000, 1'b1};
    vecs[1] = '{13'h000, '{13'h0, 13'h0, 13'h0, 13'h4}, '{13'd0, 13'd0, 13'd0, 13'd1}, 1'b1, 4'd6,
                '{13'h0, 13'h4, 13'h0, 13'h4, 13'h0, 13'h4, 13'h0, 13'h0},
                8'b0010_1010, 1'b0};
    vecs[2] = '{13'h005, '{13'h0, 13'h0, 13'h0, 13'h1FFE}, '{13'd0, 13'd0, 13'd0, 13'd3}, 1'b0, 4'd4,
                '{13'h5, 13'h3, 13'h1, 13'h1FFF, 13'h0, 13'h0, 13'h0, 13'h0},
                8'b0000_1000, 1'b1};
    vecs[3] = '{13'hABC, '{13'h0, 13'h0, 13'h0, 13'h5}, '{13'd0, 13'd0, 13'd0, 13'd0}, 1'b0, 4'd1,
                '{13'hABC, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0, 13'h0},
                8'b0000_0001, 1'b1};
    foreach (vecs[i]) apply_vec(vecs[i]);

    // same six-address sequence under a 1010.. ready pattern
    g = '{0, 0, 'h10, 1, 0, 0};
    l = '{0, 0, 1, 2, 0, 0};
    run_seq(0, 'h100, g, l, 1'b0, 1);

    // abort with a pending address; start wins over the same-cycle handshake
    base_a = 13'h100; wrap_a = 1'b0;
    gap_a = '0; len_a = '0;
    gap_a[2*13 +: 13] = 13'h10; gap_a[3*13 +: 13] = 13'h1;
    len_a[2*13 +: 13] = 13'd1;  len_a[3*13 +: 13] = 13'd2;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    rdy_a = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_pending", int'(out_a), 'h102);
    base_a = 13'h20;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("abort_addr", int'(out_a), 'h20);
    chk("abort_done", int'(done_a), 0);
    chk("abort_vld", int'(vld_a), 1);
    @(posedge clk); #1;
    chk("abort_next", int'(out_a), 'h21);
    chk("abort_done2", int'(done_a), 0);
    rdy_a = 1'b0;

    // reset in the middle of a run
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_vld", int'(vld_a), 0);
    chk("midrst_addr", int'(out_a), 0);
    chk("midrst_last", int'(last_a), 0);
    chk("midrst_done", int'(done_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    @(posedge clk); #1;
    chk("midrst_idle", int'(vld_a), 0);
    chk("midrst_nodone", int'(done_a), 0);

    // randomized configs; odd runs exercise the 6-level, 16-bit instance
    for (int r = 0; r < 12; r++) begin
      which = r % 2;
      nl    = (which == 0) ? 4 : 6;
      aw    = (which == 0) ? 13 : 16;
      mask  = (1 << aw) - 1;
      for (int i = 0; i < 6; i++) begin
        g[i] = (i < nl) ? int'($urandom) & mask : 0;
        l[i] = (i < nl) ? int'($urandom_range(0, 2)) : 0;
      end
      wrap = 1'($urandom_range(0, 1));
      run_seq(which, int'($urandom) & mask, g, l, wrap, (r / 2) % 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
